// File: rtl/debug_data_receiver.sv
// debug_data_receiver: captures LSB-first framed words from the debug serial
// link and presents them on a parallel port with a valid/ack handshake.
// Framing errors (short/long frames) and overruns are reported as sticky flags.
module debug_data_receiver #(
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             frame,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ack,
    output logic             busy,
    output logic             err_short,
    output logic             err_long,
    output logic             overrun,
    input  logic             clr_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_SHIFT,
        ST_TAIL
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
    logic             err_short_q, err_short_d;
    logic             err_long_q, err_long_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] shifted;
    logic             capture;
    logic             set_short;
    logic             set_long;

    // New bits enter at the MSB so the first bit ends up at bit 0 after WIDTH shifts.
    assign shifted = {sin, sr_q[WIDTH-1:1]};

    // Framing state machine: tracks where we are inside a frame and decides capture/errors.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        count_d   = count_q;
        capture   = 1'b0;
        set_short = 1'b0;
        set_long  = 1'b0;
        unique case (state_q)
            // A frame already running at reset release is skipped entirely.
            ST_SYNC: begin
                if (!frame) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (frame) begin
                    sr_d    = shifted;
                    count_d = CW'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!frame) begin
                    // Partial word is dropped; the low frame sample is not a bit.
                    set_short = 1'b1;
                    count_d   = '0;
                    state_d   = ST_IDLE;
                end else begin
                    sr_d    = shifted;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        capture = 1'b1;
                        state_d = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                if (frame) begin
                    set_long = 1'b1;
                end else begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    // Output side: handshake and sticky flags; a set condition beats clr_err.
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        if (capture) begin
            data_d  = shifted;
            valid_d = 1'b1;
        end else if (ack) begin
            valid_d = 1'b0;
        end
        err_short_d = set_short | (err_short_q & ~clr_err);
        err_long_d  = set_long | (err_long_q & ~clr_err);
        overrun_d   = (capture & valid_q & ~ack) | (overrun_q & ~clr_err);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SYNC;
            sr_q        <= '0;
            count_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            count_q     <= count_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign busy      = (state_q == ST_SHIFT);
    assign err_short = err_short_q;
    assign err_long  = err_long_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_debug_data_receiver.sv
// Bench for debug_data_receiver: directed frames, a frame-run-length model
// checked every cycle, and literal expectations after each scenario.
module tb_debug_data_receiver;

    localparam int W = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sin = 1'b0;
    logic          frame = 1'b0;
    logic          ack = 1'b0;
    logic          clr_err = 1'b0;
    logic [W-1:0]  data_out;
    logic          valid;
    logic          busy;
    logic          err_short;
    logic          err_long;
    logic          overrun;

    int vectors = 0;
    int miscompares = 0;

    debug_data_receiver #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sin      (sin),
        .frame    (frame),
        .data_out (data_out),
        .valid    (valid),
        .ack      (ack),
        .busy     (busy),
        .err_short(err_short),
        .err_long (err_long),
        .overrun  (overrun),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;

    // Model: reasons about runs of consecutive high frame samples.
    // A run of exactly W samples (or the first W of a longer run) is a word;
    // a run that ends before W is a short frame; samples beyond W are a long frame.
    // A run already in progress at reset release is ignored until frame is seen low.
    logic [W-1:0] m_data = '0;
    logic [W-1:0] m_bits = '0;
    bit           m_valid = 0, m_es = 0, m_el = 0, m_ov = 0, m_busy = 0;
    bit           m_armed = 0;
    int           m_run = 0;

    initial begin : model
        bit cap, shrt, lng;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_data = '0; m_bits = '0; m_valid = 0; m_es = 0; m_el = 0;
                m_ov = 0; m_busy = 0; m_armed = 0; m_run = 0;
            end else begin
                cap = 0; shrt = 0; lng = 0;
                if (!frame) begin
                    shrt = m_armed && (m_run > 0) && (m_run < W);
                    m_run = 0;
                    m_armed = 1;
                end else if (m_armed) begin
                    m_run = m_run + 1;
                    if (m_run <= W) m_bits[m_run-1] = sin;
                    cap = (m_run == W);
                    lng = (m_run > W);
                end
                m_ov = (cap && m_valid && !ack) || (m_ov && !clr_err);
                m_es = shrt || (m_es && !clr_err);
                m_el = lng || (m_el && !clr_err);
                if (cap) begin
                    m_data = m_bits;
                    m_valid = 1;
                end else if (ack) begin
                    m_valid = 0;
                end
                m_busy = (m_run >= 1) && (m_run <= W - 1);
            end
        end
    end

    task automatic fld(input string n, input logic [W-1:0] g, input logic [W-1:0] e, inout bit bad);
        if (g !== e) begin
            bad = 1;
            $display("FAIL cycle %s: got %h expected %h at %0t", n, g, e, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit bad;
        bad = 0;
        vectors++;
        fld("data_out", data_out, m_data, bad);
        fld("valid", W'(valid), W'(m_valid), bad);
        fld("busy", W'(busy), W'(m_busy), bad);
        fld("err_short", W'(err_short), W'(m_es), bad);
        fld("err_long", W'(err_long), W'(m_el), bad);
        fld("overrun", W'(overrun), W'(m_ov), bad);
        if (bad) miscompares++;
    end

    task automatic chk(input string n, input logic [W-1:0] g, input logic [W-1:0] e);
        vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", n, g, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends nbits frame samples (bits past W are 1s), then one low gap clock.
    task automatic send(input logic [W-1:0] w, input int nbits, input bit ack_last, input bit ack_gap);
        $display("[%0t] send word=%h bits=%0d ack_last=%0d ack_gap=%0d", $time, w, nbits, ack_last, ack_gap);
        for (int i = 0; i < nbits; i++) begin
            frame = 1'b1;
            sin   = (i < W) ? w[i] : 1'b1;
            ack   = ack_last && (i == nbits - 1);
            tick();
        end
        frame = 1'b0;
        sin   = 1'b0;
        ack   = ack_gap;
        tick();
        ack   = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
    endtask

    localparam logic [W-1:0] WA = 40'hA999999991;
    localparam logic [W-1:0] WE = 40'hE999999993;
    localparam logic [W-1:0] WL = 40'h5A5A5A5A5A;
    localparam logic [W-1:0] WR = 40'h0123456789;

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset data_out", data_out, '0);
        chk("reset valid", W'(valid), '0);
        chk("reset flags", W'({busy, err_short, err_long, overrun}), '0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single word
        send(WA, W, 0, 0);
        chk("single data_out", data_out, WA);
        chk("single valid", W'(valid), W'(1));
        chk("single flags", W'({err_short, err_long, overrun}), '0);
        pulse_ack();
        chk("ack clears valid", W'(valid), '0);

        // Back-to-back with ack in the gap
        send(WA, W, 0, 1);
        chk("b2b first data", data_out, WA);
        send(WE, W, 0, 1);
        chk("b2b second data", data_out, WE);
        chk("b2b no overrun", W'(overrun), '0);

        // Back-to-back without ack -> overrun
        send(WA, W, 0, 0);
        send(WE, W, 0, 0);
        chk("overrun data", data_out, WE);
        chk("overrun flag", W'(overrun), W'(1));
        chk("overrun valid", W'(valid), W'(1));
        pulse_clr();
        chk("clr overrun", W'(overrun), '0);
        pulse_ack();

        // Short frame with a pending word
        send(WA, W, 0, 0);
        send(WE, 25, 0, 0);
        chk("short err_short", W'(err_short), W'(1));
        chk("short valid kept", W'(valid), W'(1));
        chk("short data kept", data_out, WA);
        pulse_ack();
        send(WE, W, 0, 0);
        chk("after short data", data_out, WE);
        chk("after short valid", W'(valid), W'(1));
        pulse_clr();
        chk("clr err_short", W'(err_short), '0);
        pulse_ack();

        // Long frame
        send(WL, 43, 0, 0);
        chk("long data", data_out, WL);
        chk("long err_long", W'(err_long), W'(1));
        chk("long busy", W'(busy), '0);
        pulse_clr();
        chk("clr err_long", W'(err_long), '0);
        pulse_ack();

        // Ack collides with capture
        send(WA, W, 0, 0);
        send(WE, W, 1, 0);
        chk("collide valid", W'(valid), W'(1));
        chk("collide data", data_out, WE);
        chk("collide overrun", W'(overrun), '0);

        // Reset in the middle of a frame (valid is 1 going in)
        $display("[%0t] reset mid-word", $time);
        for (int i = 0; i < W; i++) begin
            frame = 1'b1;
            sin   = WA[i];
            if (i == 17) begin
                rst_n = 1'b0;
                #1;
                chk("midreset data_out", data_out, '0);
                chk("midreset valid", W'(valid), '0);
                chk("midreset busy", W'(busy), '0);
            end
            if (i == 20) rst_n = 1'b1;
            tick();
        end
        frame = 1'b0;
        sin   = 1'b0;
        tick();
        chk("post-reset no valid", W'(valid), '0);
        chk("post-reset no err_short", W'(err_short), '0);
        send(WR, W, 0, 0);
        chk("post-reset data", data_out, WR);
        chk("post-reset valid", W'(valid), W'(1));

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
